// File: rtl/nic_tx_pkg.sv
// nic_tx_pkg: constants and FSM state type shared by the NIC transmit path
// (packet arbiter and the 64-to-8 width converter).
package nic_tx_pkg;
    localparam int TX_DATA_W    = 64;
    localparam int TX_KEEP_W    = TX_DATA_W / 8;
    localparam int TX_MAX_BEATS = 190;

    typedef enum logic [1:0] {IDLE, PASS, DRAIN} tx_state_e;
endpackage

// File: rtl/tx_pkt_arbiter_axis_out_reg.sv
// axis_out_reg: single-stage registered AXI-Stream slice; a new beat may be
// loaded whenever the stage is empty or is being emptied in the same cycle.
module axis_out_reg
    import nic_tx_pkg::*;
#(
    parameter int DATA_W = TX_DATA_W,
    parameter int KEEP_W = TX_KEEP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_load,
    input  logic [DATA_W-1:0] in_data,
    input  logic [KEEP_W-1:0] in_keep,
    input  logic              in_last,
    input  logic              in_user,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [KEEP_W-1:0] out_keep,
    output logic              out_valid,
    output logic              out_last,
    output logic              out_user,
    input  logic              out_ready
);
    logic [DATA_W-1:0] data_q, data_d;
    logic [KEEP_W-1:0] keep_q, keep_d;
    logic              valid_q, valid_d, last_q, last_d, user_q, user_d;

    always_comb begin
        valid_d = in_load || (valid_q && !out_ready);
        data_d  = in_load ? in_data : data_q;
        keep_d  = in_load ? in_keep : keep_q;
        last_d  = in_load ? in_last : last_q;
        user_d  = in_load ? in_user : user_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            user_q  <= user_d;
        end
    end

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_last  = last_q;
    assign out_user  = user_q;
endmodule

// File: rtl/tx_pkt_arbiter.sv
// tx_pkt_arbiter: two-port packet-granular round-robin arbiter onto the TX
// AXI-Stream; over-long packets are cut with tuser set and the rest drained.
module tx_pkt_arbiter
    import nic_tx_pkg::*;
#(
    parameter int DATA_W    = TX_DATA_W,
    parameter int KEEP_W    = TX_KEEP_W,
    parameter int MAX_BEATS = TX_MAX_BEATS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s0_axis_tdata,
    input  logic [KEEP_W-1:0] s0_axis_tkeep,
    input  logic              s0_axis_tvalid,
    input  logic              s0_axis_tlast,
    input  logic              s0_axis_tuser,
    output logic              s0_axis_tready,
    input  logic [DATA_W-1:0] s1_axis_tdata,
    input  logic [KEEP_W-1:0] s1_axis_tkeep,
    input  logic              s1_axis_tvalid,
    input  logic              s1_axis_tlast,
    input  logic              s1_axis_tuser,
    output logic              s1_axis_tready,
    output logic [DATA_W-1:0] tx_axis_tdata,
    output logic [KEEP_W-1:0] tx_axis_tkeep,
    output logic              tx_axis_tvalid,
    output logic              tx_axis_tlast,
    output logic              tx_axis_tuser,
    input  logic              tx_axis_tready,
    output logic [15:0]       abort_cnt
);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    tx_state_e         state_q, state_d;
    logic              gnt_q, gnt_d, pri_q, pri_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [15:0]       abort_cnt_q, abort_cnt_d;
    logic [DATA_W-1:0] sel_data;
    logic [KEEP_W-1:0] sel_keep;
    logic              sel_valid, sel_last, sel_user;
    logic              out_ready, s_ready, accept, load, trunc, done;

    assign sel_data  = gnt_q ? s1_axis_tdata  : s0_axis_tdata;
    assign sel_keep  = gnt_q ? s1_axis_tkeep  : s0_axis_tkeep;
    assign sel_valid = gnt_q ? s1_axis_tvalid : s0_axis_tvalid;
    assign sel_last  = gnt_q ? s1_axis_tlast  : s0_axis_tlast;
    assign sel_user  = gnt_q ? s1_axis_tuser  : s0_axis_tuser;

    assign s_ready = (state_q == PASS) ? out_ready : (state_q == DRAIN);
    assign accept  = sel_valid && s_ready;
    assign load    = accept && (state_q == PASS);
    // A genuine tlast on the limit beat is a normal packet end, not a truncation.
    assign trunc   = load && !sel_last && (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
    assign done    = accept && sel_last;

    assign s0_axis_tready = s_ready && !gnt_q;
    assign s1_axis_tready = s_ready && gnt_q;
    assign abort_cnt      = abort_cnt_q;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        beat_cnt_d  = beat_cnt_q;
        abort_cnt_d = abort_cnt_q;
        case (state_q)
            IDLE: if (s0_axis_tvalid || s1_axis_tvalid) begin
                gnt_d      = (s0_axis_tvalid && s1_axis_tvalid) ? pri_q : s1_axis_tvalid;
                beat_cnt_d = '0;
                state_d    = PASS;
            end
            PASS: if (load) begin
                beat_cnt_d  = beat_cnt_q + CNT_W'(1);
                abort_cnt_d = abort_cnt_q + 16'(trunc && (abort_cnt_q != 16'hFFFF));
                state_d     = done ? IDLE : (trunc ? DRAIN : PASS);
            end
            DRAIN: if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        pri_d = done ? ~gnt_q : pri_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            pri_q       <= 1'b0;
            beat_cnt_q  <= '0;
            abort_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            pri_q       <= pri_d;
            beat_cnt_q  <= beat_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    axis_out_reg #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_load   (load),
        .in_data   (sel_data),
        .in_keep   (sel_keep),
        .in_last   (sel_last || trunc),
        .in_user   (sel_user || trunc),
        .in_ready  (out_ready),
        .out_data  (tx_axis_tdata),
        .out_keep  (tx_axis_tkeep),
        .out_valid (tx_axis_tvalid),
        .out_last  (tx_axis_tlast),
        .out_user  (tx_axis_tuser),
        .out_ready (tx_axis_tready)
    );
endmodule

// File: doc/tx_pkt_arbiter.md
# tx_pkt_arbiter

Two-input, packet-granular round-robin arbiter for the NIC transmit path. It shares the single 64-bit AXI-Stream TX interface between two requesters (port 0 and port 1, e.g. two descriptor queues) and feeds the 64-to-8 TX width converter in front of the MAC. Once a port is granted, the grant is held until that packet's `tlast` beat is accepted. Packets longer than a configured beat limit are truncated and flagged as errored toward the MAC; the unsent remainder is drained.

## Interface

- `DATA_W`, 64, data width of all streams
- `KEEP_W`, 8, byte-enable width (`DATA_W/8`)
- `MAX_BEATS`, 190, maximum beats per packet before forced truncation (190 × 8 = 1520 bytes)
- `clk` in 1 — single clock for all logic
- `rst_n` in 1 — reset, asynchronous assert, active-low
- `s0_axis_tdata` / `s1_axis_tdata` in DATA_W — requester data
- `s0_axis_tkeep` / `s1_axis_tkeep` in KEEP_W — byte enables, LSB-contiguous, meaningful only on the `tlast` beat
- `s0_axis_tvalid` / `s1_axis_tvalid` in 1 — beat valid
- `s0_axis_tlast` / `s1_axis_tlast` in 1 — last beat of packet
- `s0_axis_tuser` / `s1_axis_tuser` in 1 — error/abort flag, sampled on the `tlast` beat
- `s0_axis_tready` / `s1_axis_tready` out 1 — beat accepted
- `tx_axis_tdata` out DATA_W — to width converter
- `tx_axis_tkeep` out KEEP_W
- `tx_axis_tvalid`, `tx_axis_tlast`, `tx_axis_tuser` out 1
- `tx_axis_tready` in 1 — from width converter
- `abort_cnt` out 16 — saturating count of truncated packets

## Operation

- FSM states:
  - IDLE: no grant.
  - PASS: forwarding beats from the granted port `gnt`.
  - DRAIN: discarding beats from `gnt`.
- Round-robin pointer `pri` names the favoured port. Reset value is 0.
- IDLE:
  - Only one port valid: that port wins.
  - Both ports valid: port `pri` wins.
  - The winner is latched into `gnt`, `beat_cnt` is cleared to 0, and the FSM moves to PASS on the next cycle.
  - No `s*_tready` is asserted in IDLE.
- PASS:
  - `s{gnt}_axis_tready = !tx_axis_tvalid || tx_axis_tready`. The other port's `tready` is 0.
  - An accepted beat is loaded into the output register with fields unchanged, and `beat_cnt` increments.
  - Accepted beat with `tlast` = 1: set `pri <= ~gnt` and go to IDLE.
  - Accepted beat with `tlast` = 0 and `beat_cnt == MAX_BEATS-1`:
    - Forward the beat with `tx_axis_tlast` = 1, `tx_axis_tuser` = 1, and `tkeep` as received.
    - `abort_cnt` increments, saturating at 0xFFFF.
    - Go to DRAIN.
- DRAIN:
  - `s{gnt}_axis_tready` = 1 unconditionally. Accepted beats are discarded.
  - When the `tlast` beat is accepted: set `pri <= ~gnt` and go to IDLE.
  - The output register is not loaded in DRAIN. A pending output beat still completes normally.
- `beat_cnt` width is `$clog2(MAX_BEATS+1)`. It never wraps, because truncation triggers before the counter can overflow.
- `tkeep` and `tuser` are passed through without checking.

## Timing

- Output register is a single stage:
  - Loaded on `s_tvalid && s_tready`.
  - Cleared (`tx_axis_tvalid` = 0) on `tx_axis_tready` with no new load.
  - Load and drain in the same cycle sustain one beat per cycle.
- Latency from an accepted input beat to `tx_axis_tvalid` is 1 cycle.
- Arbitration overhead is one bubble per packet: the IDLE cycle between a `tlast` acceptance and the next grant.
- Reset values:
  - All `tx_axis_*` outputs 0.
  - `s*_axis_tready` 0.
  - `abort_cnt` 0.
  - State IDLE, `pri` 0, `beat_cnt` 0.
- Reset mid-packet: all state clears immediately. Any partially sent packet is lost. Upstream and the MAC must also be reset.
- A requester that drops `tvalid` mid-packet keeps the grant. The arbiter never re-arbitrates before `tlast`.
- A single-beat packet (`tlast` on the first beat) returns to IDLE after one accepted beat.
- The truncation beat and a genuine `tlast` can coincide at `MAX_BEATS-1`. Genuine `tlast` wins: the beat is forwarded normally, `abort_cnt` does not increment, and the FSM goes to IDLE.

## Structure

- Shared package `nic_tx_pkg` holds:
  - The state enum (IDLE, PASS, DRAIN).
  - `TX_DATA_W`, `TX_KEEP_W`, and `TX_MAX_BEATS` constants, also used by the width converter.
- Natural sub-module: `axis_out_reg`, the one-stage registered AXIS slice with ready generation. The arbiter FSM and mux stay in the top module.

## Test plan

- Only port 0 sends a 3-beat packet (data 0x11…, 0x22…, 0x33…, last `tkeep` 0x0F), with `tx_axis_tready` = 1:
  - Output shows 3 beats, starting 2 cycles after the first `s0_axis_tvalid`.
  - `tlast` is on the third beat with `tkeep` 0x0F.
  - `s1_axis_tready` stays 0 throughout.
- Both ports continuously valid with 2-beat packets:
  - Output packet order is 0, 1, 0, 1.
  - Exactly one idle cycle separates consecutive packets.
- Port 0 sends a 200-beat packet with `MAX_BEATS` = 190:
  - Output has 190 beats, the 190th with `tlast` = 1 and `tuser` = 1.
  - The remaining 10 beats are consumed with no output.
  - `abort_cnt` = 1, and the next grant goes to port 1.
- Port 0 sends exactly 190 beats with `tlast` on beat 190:
  - Normal forward with `tuser` = 0.
  - `abort_cnt` stays 0.
- `tx_axis_tready` toggles 1,0,0,1 during a 4-beat packet:
  - No beat is lost or duplicated, and `tx_axis_tdata` is stable while `tready` = 0.
  - Port 1 going valid mid-packet is not granted until after `tlast`.
- `rst_n` pulsed low mid-packet (beat 2 of 5):
  - All outputs 0 asynchronously.
  - After release, port 1 valid alone is granted in IDLE.
